// File: rtl/bcd_display_counter.sv
// 4-digit BCD up/down counter advanced by a synchronized 1 Hz strobe,
// time-multiplexed onto a common-anode 7-segment display (active-low).
module bcd_display_counter #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        clk_1Hz,
    input  logic        en,
    input  logic        clr,
    input  logic        up_dn,
    output logic [15:0] count,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic              sync0, sync1, prev;
    logic              tick;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_sel;
    logic [15:0]       count_next;
    logic              wrap_next;
    logic [3:0]        cur_digit;
    logic              blank;

    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Reset to 1 so a divider output already high at release is not seen as an edge.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync0 <= clk_1Hz;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    assign tick = sync1 & ~prev;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = 16'h0000;
        end else if (tick && en) begin
            count_next = bcd_step(count, up_dn);
            wrap_next  = up_dn ? (count == 16'h9999) : (count == 16'h0000);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            count <= 16'h0000;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_digit = count[4*digit_sel +: 4];
        case (digit_sel)
            2'd3:    blank = BLANK_LZ && (count[15:12] == 4'h0);
            2'd2:    blank = BLANK_LZ && (count[15:8]  == 8'h00);
            2'd1:    blank = BLANK_LZ && (count[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_ZERO;
        end else begin
            an  <= ~(4'b0001 << digit_sel);
            seg <= blank ? SEG_BLANK : seg_decode(cur_digit);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Bench for bcd_display_counter: integer-valued reference model checked every
// cycle, plus directed literal checks on latency, wrap, scan and reset.
module tb_bcd_display_counter;

    localparam int SD = 4;

    logic        clk_100MHz = 1'b0;
    logic        rst = 1'b0;
    logic        clk_1Hz = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        up_dn = 1'b1;
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_display_counter #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .clk_1Hz(clk_1Hz), .en(en),
        .clr(clr), .up_dn(up_dn), .count(count), .wrap(wrap), .an(an),
        .seg(seg), .dp(dp)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: count as a plain integer 0..9999, scan position from
    // cycles elapsed since reset, tick from the history of sampled clk_1Hz.
    int         pow10 [4] = '{1, 10, 100, 1000};
    logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int         m_count, m_t;
    bit         m_wrap, m_valid = 0;
    bit         h1, h2, h3;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    always @(posedge clk_100MHz) begin
        int  dsel;
        bit  tk;
        if (rst) begin
            m_count = 0; m_wrap = 0; m_t = 0;
            m_an = 4'b1110; m_seg = 7'b1000000;
            h1 = 1; h2 = 1; h3 = 1;
            m_valid = 1;
        end else begin
            dsel  = (m_t / SD) % 4;
            m_an  = ~(4'b0001 << dsel);
            m_seg = (dsel > 0 && m_count < pow10[dsel]) ? 7'b1111111
                                                         : dec_tab[(m_count / pow10[dsel]) % 10];
            tk = h2 && !h3;
            m_wrap = 0;
            if (clr) begin
                m_count = 0;
            end else if (tk && en) begin
                if (up_dn) begin
                    m_wrap  = (m_count == 9999);
                    m_count = (m_count + 1) % 10000;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count == 0) ? 9999 : m_count - 1;
                end
            end
            h3 = h2; h2 = h1; h1 = clk_1Hz;
            m_t++;
        end
    end

    always @(negedge clk_100MHz) begin
        if (m_valid) begin
            check("count", 32'(count), 32'(to_bcd(m_count)));
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("an", 32'(an), 32'(m_an));
            check("seg", 32'(seg), 32'(m_seg));
            check("dp", 32'(dp), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk_100MHz);
        #2;
    endtask

    task automatic tick_once();
        clk_1Hz = 1'b1;
        repeat (2) step();
        clk_1Hz = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        logic [3:0] seen;
        bit         found;

        rst = 1'b1; clk_1Hz = 1'b1;
        step();
        check("rst_an", 32'(an), 32'h0000000e);
        check("rst_seg", 32'(seg), 32'h00000040);
        check("rst_count", 32'(count), 32'h0);
        rst = 1'b0;
        repeat (10) step();
        check("hi_release_count", 32'(count), 32'h0);

        en = 1'b1; up_dn = 1'b1; clk_1Hz = 1'b0;
        repeat (3) step();
        clk_1Hz = 1'b1;
        step();
        check("lat_edge_n", 32'(count), 32'h0);
        step();
        check("lat_edge_n1", 32'(count), 32'h0);
        step();
        check("lat_edge_n2", 32'(count), 32'h1);
        clk_1Hz = 1'b0;
        repeat (2) step();
        repeat (4) tick_once();
        check("five_ticks", 32'(count), 32'h0005);
        check("five_ticks_wrap", 32'(wrap), 32'h0);

        clr = 1'b1; step(); clr = 1'b0;
        check("clr_only", 32'(count), 32'h0);
        up_dn = 1'b0;
        clk_1Hz = 1'b1;
        repeat (3) step();
        check("down_wrap_count", 32'(count), 32'h9999);
        check("down_wrap_pulse", 32'(wrap), 32'h1);
        clk_1Hz = 1'b0;
        step();
        check("down_wrap_end", 32'(wrap), 32'h0);
        step();
        up_dn = 1'b1;
        clk_1Hz = 1'b1;
        repeat (3) step();
        check("up_wrap_count", 32'(count), 32'h0);
        check("up_wrap_pulse", 32'(wrap), 32'h1);
        clk_1Hz = 1'b0;
        step();
        check("up_wrap_end", 32'(wrap), 32'h0);
        step();

        repeat (42) tick_once();
        check("count_42", 32'(count), 32'h0042);
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            step();
            case (an)
                4'b1110: begin seen[0] = 1'b1; check("scan_d0", 32'(seg), 32'h24); end
                4'b1101: begin seen[1] = 1'b1; check("scan_d1", 32'(seg), 32'h19); end
                4'b1011: begin seen[2] = 1'b1; check("scan_d2", 32'(seg), 32'h7f); end
                4'b0111: begin seen[3] = 1'b1; check("scan_d3", 32'(seg), 32'h7f); end
                default: check("scan_an_onehot", 32'(an), 32'h0000000e);
            endcase
        end
        check("scan_all_digits", 32'(seen), 32'hf);

        repeat (81) tick_once();
        check("count_123", 32'(count), 32'h0123);
        en = 1'b0;
        tick_once();
        check("en_low_hold", 32'(count), 32'h0123);
        en = 1'b1;
        clk_1Hz = 1'b1;
        repeat (2) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_beats_tick", 32'(count), 32'h0);
        check("clr_beats_tick_wrap", 32'(wrap), 32'h0);
        clk_1Hz = 1'b0;
        repeat (3) step();

        repeat (777) tick_once();
        check("count_777", 32'(count), 32'h0777);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (an == 4'b1011) found = 1;
        end
        check("found_digit2", 32'(found), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_an", 32'(an), 32'h0000000e);
        check("midrst_seg", 32'(seg), 32'h00000040);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
